// File: rtl/switch_box_cfg.sv
`default_nettype none
// ============================================================================
//  switch_box_cfg : run-time configurable routing switch box with shadow /
//  active configuration banks and a break-before-make commit sequence.
//  Revision: 1.0
// ============================================================================
module switch_box_cfg #(
    parameter int TB_W      = 5,
    parameter int LR_W      = 4,
    parameter int IDX_W     = 3,
    parameter int ADDR_W    = 5,
    parameter int BLANK_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TB_W-1:0]      top_i,
    input  logic [TB_W-1:0]      bot_i,
    input  logic [LR_W-1:0]      left_i,
    input  logic [LR_W-1:0]      right_i,
    output logic [TB_W-1:0]      top_o,
    output logic [TB_W-1:0]      top_oe,
    output logic [TB_W-1:0]      bot_o,
    output logic [TB_W-1:0]      bot_oe,
    output logic [LR_W-1:0]      left_o,
    output logic [LR_W-1:0]      left_oe,
    output logic [LR_W-1:0]      right_o,
    output logic [LR_W-1:0]      right_oe,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [ADDR_W-1:0]    cfg_addr,
    input  logic [IDX_W+2:0]     cfg_data,
    input  logic                 commit_req,
    output logic                 commit_done,
    output logic                 cfg_err,
    input  logic [ADDR_W-1:0]    cfg_rd_addr,
    output logic [IDX_W+2:0]     cfg_rd_data
);

    localparam int N_OUT  = 2*TB_W + 2*LR_W;
    localparam int DATA_W = 3 + IDX_W;
    localparam int EXT_W  = 2**IDX_W;
    localparam int CNT_W  = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

    // Bit k set when index k exists on that side; wider indices mean "off".
    localparam logic [EXT_W-1:0]  c_TB_MASK  = {EXT_W{1'b1}} >> (EXT_W - TB_W);
    localparam logic [EXT_W-1:0]  c_LR_MASK  = {EXT_W{1'b1}} >> (EXT_W - LR_W);
    localparam logic [ADDR_W:0]   c_N_OUT_X  = (ADDR_W+1)'(N_OUT);
    localparam logic [CNT_W-1:0]  c_CNT_LOAD = CNT_W'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ready;
    logic                r_oe_en;
    logic                r_done;
    logic                r_err;
    logic [DATA_W-1:0]   r_shadow [N_OUT];
    logic [DATA_W-1:0]   r_active [N_OUT];
    logic [DATA_W-1:0]   r_rd_data;

    logic                w_wr_legal;
    logic                w_wr_en;
    logic                w_apply;
    logic [DATA_W-1:0]   w_rd_mux;
    logic [EXT_W-1:0]    w_top_x;
    logic [EXT_W-1:0]    w_bot_x;
    logic [EXT_W-1:0]    w_left_x;
    logic [EXT_W-1:0]    w_right_x;
    logic [N_OUT-1:0]    w_o_all;
    logic [N_OUT-1:0]    w_oe_all;

    assign w_wr_legal = ({1'b0, cfg_addr} < c_N_OUT_X);
    assign w_wr_en    = (r_state == ST_IDLE) && cfg_valid;
    assign w_apply    = (r_state == ST_APPLY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_oe_en <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_valid && !w_wr_legal) begin
                        r_err <= 1'b1;
                    end
                    if (commit_req) begin
                        r_state <= ST_BLANK;
                        r_cnt   <= c_CNT_LOAD;
                        r_ready <= 1'b0;
                        r_oe_en <= 1'b0;
                    end
                end
                ST_BLANK: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_APPLY;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_APPLY: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_oe_en <= 1'b1;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_oe_en <= 1'b1;
                end
            endcase
        end
    end

    // Illegal addresses match no entry, so those writes drop out naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_OUT; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (w_wr_en && (cfg_addr == ADDR_W'(i))) begin
                    r_shadow[i] <= cfg_data;
                end
                if (w_apply) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (cfg_rd_addr == ADDR_W'(i)) begin
                w_rd_mux = r_active[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign w_top_x   = EXT_W'(top_i);
    assign w_bot_x   = EXT_W'(bot_i);
    assign w_left_x  = EXT_W'(left_i);
    assign w_right_x = EXT_W'(right_i);

    for (genvar p = 0; p < N_OUT; p++) begin : g_pin
        logic [2:0]       w_side;
        logic [IDX_W-1:0] w_idx;
        logic             w_hit;
        logic             w_val;

        assign w_side = r_active[p][2:0];
        assign w_idx  = r_active[p][DATA_W-1:3];

        always_comb begin
            w_hit = 1'b0;
            w_val = 1'b0;
            case (w_side)
                3'd1: begin
                    w_hit = c_TB_MASK[w_idx];
                    w_val = w_top_x[w_idx];
                end
                3'd2: begin
                    w_hit = c_LR_MASK[w_idx];
                    w_val = w_right_x[w_idx];
                end
                3'd3: begin
                    w_hit = c_TB_MASK[w_idx];
                    w_val = w_bot_x[w_idx];
                end
                3'd4: begin
                    w_hit = c_LR_MASK[w_idx];
                    w_val = w_left_x[w_idx];
                end
                default: begin
                    w_hit = 1'b0;
                    w_val = 1'b0;
                end
            endcase
        end

        assign w_o_all[p]  = w_hit & w_val;
        assign w_oe_all[p] = w_hit;
    end

    assign top_o    = w_o_all[TB_W-1:0];
    assign bot_o    = w_o_all[2*TB_W-1:TB_W];
    assign left_o   = w_o_all[2*TB_W+LR_W-1:2*TB_W];
    assign right_o  = w_o_all[N_OUT-1:2*TB_W+LR_W];

    assign top_oe   = w_oe_all[TB_W-1:0]                 & {TB_W{r_oe_en}};
    assign bot_oe   = w_oe_all[2*TB_W-1:TB_W]            & {TB_W{r_oe_en}};
    assign left_oe  = w_oe_all[2*TB_W+LR_W-1:2*TB_W]     & {LR_W{r_oe_en}};
    assign right_oe = w_oe_all[N_OUT-1:2*TB_W+LR_W]      & {LR_W{r_oe_en}};

    assign cfg_ready   = r_ready;
    assign commit_done = r_done;
    assign cfg_err     = r_err;
    assign cfg_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_switch_box_cfg.sv
`default_nettype none
// ============================================================================
//  tb_switch_box_cfg : directed scoreboard bench for switch_box_cfg.
//  Revision: 1.0
// ============================================================================
module tb_switch_box_cfg;

    logic       clk;
    logic       rst_n;
    logic [4:0] top_i, bot_i;
    logic [3:0] left_i, right_i;
    logic [4:0] top_o, top_oe, bot_o, bot_oe;
    logic [3:0] left_o, left_oe, right_o, right_oe;
    logic       cfg_valid, cfg_ready;
    logic [4:0] cfg_addr;
    logic [5:0] cfg_data;
    logic       commit_req, commit_done, cfg_err;
    logic [4:0] cfg_rd_addr;
    logic [5:0] cfg_rd_data;

    logic [17:0] oe_all;
    logic [17:0] o_all;
    assign oe_all = {right_oe, left_oe, bot_oe, top_oe};
    assign o_all  = {right_o, left_o, bot_o, top_o};

    switch_box_cfg #(
        .TB_W(5), .LR_W(4), .IDX_W(3), .ADDR_W(5), .BLANK_CYC(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .top_i(top_i), .bot_i(bot_i), .left_i(left_i), .right_i(right_i),
        .top_o(top_o), .top_oe(top_oe), .bot_o(bot_o), .bot_oe(bot_oe),
        .left_o(left_o), .left_oe(left_oe), .right_o(right_o), .right_oe(right_oe),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .commit_req(commit_req), .commit_done(commit_done), .cfg_err(cfg_err),
        .cfg_rd_addr(cfg_rd_addr), .cfg_rd_data(cfg_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  kind;   // 2'b10 commit_done, 2'b01 cfg_err
        logic [17:0] oe;
    } ev_t;

    ev_t sb_q[$];
    ev_t mon_ev;
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Event monitor: every done/err pulse must match the next expected event.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && (commit_done || cfg_err)) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got done=%0b err=%0b expected no event",
                             commit_done, cfg_err);
                end else begin
                    mon_ev = sb_q.pop_front();
                    chk({mon_ev.name, "_kind"}, 32'({commit_done, cfg_err}), 32'(mon_ev.kind));
                    chk({mon_ev.name, "_oe"}, 32'(oe_all), 32'(mon_ev.oe));
                end
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic wr(input logic [4:0] a, input logic [5:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [5:0] exp);
        cfg_rd_addr = a;
        @(posedge clk); #1;
        chk(name, 32'(cfg_rd_data), 32'(exp));
    endtask

    task automatic do_commit(input string name, input bit with_wr, input logic [4:0] a,
                             input logic [5:0] d, input bit second_req,
                             input logic [17:0] exp_oe);
        sb_q.push_back('{name, 2'b10, exp_oe});
        commit_req = 1'b1;
        if (with_wr) begin
            cfg_valid = 1'b1;
            cfg_addr  = a;
            cfg_data  = d;
        end
        @(posedge clk); #1;
        commit_req = second_req;
        cfg_valid  = 1'b0;
        @(negedge clk);
        chk({name, "_blank_oe"}, 32'(oe_all), 32'd0);
        chk({name, "_blank_ready"}, 32'(cfg_ready), 32'd0);
        @(posedge clk); #1;
        commit_req = 1'b0;
        @(negedge clk);
        chk({name, "_apply_oe"}, 32'(oe_all), 32'd0);
        chk({name, "_apply_ready"}, 32'(cfg_ready), 32'd0);
        @(negedge clk);
        chk({name, "_done_latency"}, 32'(commit_done), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        top_i = '0; bot_i = '0; left_i = '0; right_i = '0;
        cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        commit_req = 1'b0; cfg_rd_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_oe", 32'(oe_all), 32'd0);
        chk("rst_o", 32'(o_all), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_rd_data", 32'(cfg_rd_data), 32'd0);
        @(posedge clk); #1;

        // Basic route: top[0] <- right[2]
        wr(5'd0, 6'b010_010);
        do_commit("basic", 1'b0, 5'd0, 6'd0, 1'b0, 18'h00001);
        right_i = 4'b0100;
        #1 chk("basic_follow_hi", 32'(top_o[0]), 32'd1);
        right_i = 4'b1011;
        #1 chk("basic_follow_lo", 32'(top_o[0]), 32'd0);
        right_i = 4'b0000;

        // Shadow isolation: left[0] <- bottom[1]
        wr(5'd10, 6'b001_011);
        chk("shadow_left_oe", 32'(left_oe[0]), 32'd0);
        rd_chk("shadow_rd_before", 5'd10, 6'd0);
        do_commit("shadow", 1'b0, 5'd0, 6'd0, 1'b0, 18'h00401);
        rd_chk("shadow_rd_after", 5'd10, 6'b001_011);
        bot_i = 5'b00010;
        #1 chk("shadow_follow", 32'(left_o[0]), 32'd1);
        bot_i = '0;

        // Illegal address: one err pulse, pins unchanged
        sb_q.push_back('{"illegal_addr", 2'b01, 18'h00401});
        wr(5'd25, 6'b001_001);
        @(posedge clk); #1;
        chk("illegal_addr_oe", 32'(oe_all), 32'h00401);
        rd_chk("illegal_rd", 5'd25, 6'd0);

        // Index beyond side width: top[1] <- right[5] stays disabled
        wr(5'd1, 6'b101_010);
        do_commit("bad_index", 1'b0, 5'd0, 6'd0, 1'b0, 18'h00401);
        right_i = 4'hF;
        #1 chk("bad_index_o", 32'(top_o[1]), 32'd0);
        right_i = '0;
        rd_chk("bad_index_rd", 5'd1, 6'b101_010);

        // Write + commit together, second request during BLANK ignored
        do_commit("wr_commit", 1'b1, 5'd5, 6'b100_001, 1'b1, 18'h00421);
        top_i = 5'b10000;
        #1 chk("wr_commit_follow", 32'(bot_o[0]), 32'd1);
        top_i = '0;
        repeat (5) @(posedge clk);
        #1;

        // Reset mid-commit
        commit_req = 1'b1;
        @(posedge clk); #1;
        commit_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_oe", 32'(oe_all), 32'd0);
        chk("midrst_o", 32'(o_all), 32'd0);
        chk("midrst_ready", 32'(cfg_ready), 32'd1);
        chk("midrst_rd", 32'(cfg_rd_data), 32'd0);
        chk("midrst_done", 32'(commit_done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_oe", 32'(oe_all), 32'd0);
        rd_chk("post_rst_rd", 5'd0, 6'd0);
        top_i = '1; bot_i = '1; left_i = '1; right_i = '1;
        #1 chk("post_rst_o", 32'(o_all), 32'd0);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
